scroll_ctrl: RTL and testbench

- Sequencer for the 16-bit scroll display register (four 4-bit nibbles).
- Holds a message of up to 16 nibbles, primes the register with the first four, then shifts the window left one nibble per scroll tick, wrapping through the message continuously.
- Sits between the message source (switch or host logic writing nibbles) and the display register, driving its D and enable inputs.

---
 rtl/scroll_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/scroll_ctrl.sv | 129 ++++++++++++
 tb/tb_scroll_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scroll display sequencer.
// Holds the FSM state encoding, the window geometry and the message-length clamp.
package scroll_pkg;

    localparam int NIB_W    = 4;
    localparam int WIN_NIBS = 4;
    localparam int LEN_MIN  = 4;
    localparam int LEN_MAX  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // The window is always four nibbles wide, so shorter messages are padded up to it.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        if (len < 5'(LEN_MIN)) begin
            return 5'(LEN_MIN);
        end
        if (len > 5'(LEN_MAX)) begin
            return 5'(LEN_MAX);
        end
        return len;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV counter; tick_o is high combinationally in the last count of each period.
// Latency: first tick TICK_DIV-1 cycles after clr_i drops; no backpressure, clr_i restarts the count.
module tick_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/scroll_ctrl.sv
// Message buffer plus IDLE/PRIME/RUN sequencer driving a 4-nibble scrolling display window.
// Latency: out_D/out_EN one cycle after PRIME or a tick; no backpressure, writes accepted every cycle.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 25000000
) (
    input  logic        in_CLK,
    input  logic        in_RST_N,
    input  logic        in_WR_EN,
    input  logic [3:0]  in_WR_ADDR,
    input  logic [3:0]  in_WR_DATA,
    input  logic [4:0]  in_LEN,
    input  logic        in_START,
    input  logic        in_STOP,
    output logic [15:0] out_D,
    output logic        out_EN,
    output logic        out_BUSY,
    output logic        out_WRAP
);

    localparam int AW    = $clog2(MSG_DEPTH);
    localparam int WIN_W = NIB_W * WIN_NIBS;

    logic [NIB_W-1:0] mem_q [MSG_DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [4:0]       len_q, len_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             en_q, en_d;
    logic             wrap_q, wrap_d;

    logic             tick;
    logic             pre_clr;
    logic             ptr_last;

    // The prescaler only runs while scrolling; STOP kills a tick due in the same cycle.
    assign pre_clr = (state_q != ST_RUN) || in_STOP;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (in_CLK),
        .rst_ni (in_RST_N),
        .clr_i  (pre_clr),
        .tick_o (tick)
    );

    // Reads below sample mem_q before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (in_WR_EN) begin
            mem_q[in_WR_ADDR[AW-1:0]] <= in_WR_DATA;
        end
    end

    assign ptr_last = (5'(ptr_q) == (len_q - 5'd1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        win_d   = win_q;
        en_d    = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_START && !in_STOP) begin
                    state_d = ST_PRIME;
                    len_d   = clamp_len(in_LEN);
                end
            end
            ST_PRIME: begin
                if (in_STOP) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_RUN;
                    win_d   = {mem_q[0], mem_q[1], mem_q[2], mem_q[3]};
                    en_d    = 1'b1;
                    ptr_d   = (len_q == 5'(WIN_NIBS)) ? '0 : AW'(WIN_NIBS);
                end
            end
            ST_RUN: begin
                if (in_STOP) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else if (tick) begin
                    win_d  = {win_q[WIN_W-NIB_W-1:0], mem_q[ptr_q]};
                    en_d   = 1'b1;
                    wrap_d = ptr_last;
                    ptr_d  = ptr_last ? '0 : ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            len_q   <= 5'(LEN_MIN);
            win_q   <= '0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            win_q   <= win_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out_D    = win_q;
    assign out_EN   = en_q;
    assign out_WRAP = wrap_q;
    assign out_BUSY = (state_q == ST_PRIME) || (state_q == ST_RUN);

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: directed scenarios plus random traffic, all checked against a stream model.
module tb_scroll_ctrl;

    localparam int TD = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [4:0]  len;
    logic        start;
    logic        stop;
    logic [15:0] d;
    logic        en;
    logic        busy;
    logic        wrap;

    scroll_ctrl #(
        .MSG_DEPTH (16),
        .TICK_DIV  (TD)
    ) dut (
        .in_CLK     (clk),
        .in_RST_N   (rst_n),
        .in_WR_EN   (wr_en),
        .in_WR_ADDR (wr_addr),
        .in_WR_DATA (wr_data),
        .in_LEN     (len),
        .in_START   (start),
        .in_STOP    (stop),
        .out_D      (d),
        .out_EN     (en),
        .out_BUSY   (busy),
        .out_WRAP   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the display shows the last four nibbles of the endless stream m[0..len-1], m[0..len-1], ...
    logic [3:0]  mm [16];
    int          mmode;   // 0 idle, 1 priming, 2 scrolling
    int          mlen;
    int          mpos;    // stream index of the next nibble to append
    int          mcyc;    // cycles spent scrolling
    logic [15:0] md;
    logic        men;
    logic        mwrap;
    logic [4:0]  cur_len;

    function automatic int clampi(input int l);
        if (l < 4) return 4;
        if (l > 16) return 16;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mm[i] = 4'h0;
        mmode = 0; mlen = 4; mpos = 0; mcyc = 0;
        md = 16'h0; men = 1'b0; mwrap = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [3:0] a, input logic [3:0] dt,
                              input logic [4:0] l, input logic st, input logic sp);
        int idx;
        men   = 1'b0;
        mwrap = 1'b0;
        case (mmode)
            0: if (st && !sp) begin
                mmode = 1;
                mlen  = clampi(int'(l));
            end
            1: if (sp) mmode = 0;
               else begin
                md    = {mm[0], mm[1], mm[2], mm[3]};
                men   = 1'b1;
                mpos  = 4;
                mcyc  = 0;
                mmode = 2;
            end
            default: if (sp) mmode = 0;
               else begin
                if ((mcyc % TD) == TD - 1) begin
                    idx   = mpos % mlen;
                    md    = {md[11:0], mm[idx]};
                    men   = 1'b1;
                    mwrap = (idx == mlen - 1);
                    mpos++;
                end
                mcyc++;
            end
        endcase
        if (w) mm[a] = dt;
    endtask

    task automatic step(input logic w, input logic [3:0] a, input logic [3:0] dt,
                        input logic st, input logic sp);
        wr_en = w; wr_addr = a; wr_data = dt; len = cur_len; start = st; stop = sp;
        @(posedge clk);
        model_edge(w, a, dt, cur_len, st, sp);
        #1;
        check_eq("d", d, md);
        check_eq("en", en, men);
        check_eq("wrap", wrap, mwrap);
        check_eq("busy", busy, mmode != 0);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_en(input int budget, output int cyc);
        cyc = 0;
        do begin
            idle();
            cyc++;
        end while (!en && cyc < budget);
        if (!en) check_eq("en_timeout", 0, 1);
    endtask

    logic [15:0] basic_exp [9] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678,
                                   16'h6789, 16'h7890, 16'h8901, 16'h9012};
    logic [15:0] min_exp [4] = '{16'h1230, 16'h2301, 16'h3012, 16'h0123};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int first_wrap;
        int second_wrap;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
        len = 5'd0; start = 1'b0; stop = 1'b0; cur_len = 5'd0;
        model_reset();
        #12;
        check_eq("rst_d", d, 16'h0);
        check_eq("rst_en", en, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wrap", wrap, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Basic scroll, LEN=10
        cur_len = 5'd10;
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 4'(i), 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle();
        check_eq("basic_prime_d", d, 16'h0123);
        check_eq("basic_prime_en", en, 1'b1);
        for (int k = 0; k < 9; k++) begin
            wait_en(10, c);
            check_eq("basic_d", d, basic_exp[k]);
            check_eq("basic_wrap", wrap, k == 5);
            check_eq("basic_gap", c, TD);
        end

        // STOP on the tick cycle, then restart
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle();
        check_eq("restart_d", d, 16'h0123);
        for (int k = 0; k < 3; k++) wait_en(10, c);
        check_eq("pre_stop_d", d, 16'h3456);
        for (int k = 0; k < TD - 1; k++) idle();
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        check_eq("stop_en", en, 1'b0);
        check_eq("stop_d", d, 16'h3456);
        check_eq("stop_busy", busy, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle();
        check_eq("reprime_d", d, 16'h0123);
        check_eq("reprime_en", en, 1'b1);

        // Minimum length, then a length below the minimum
        for (int p = 0; p < 2; p++) begin
            step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
            cur_len = (p == 0) ? 5'd4 : 5'd2;
            step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
            idle();
            check_eq("min_prime_d", d, 16'h0123);
            for (int k = 0; k < 4; k++) begin
                wait_en(10, c);
                check_eq("min_d", d, min_exp[k]);
                check_eq("min_wrap", wrap, k == 3);
            end
        end

        // START and STOP together in IDLE
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        check_eq("ss_busy", busy, 1'b0);
        for (int k = 0; k < 3; k++) idle();
        check_eq("ss_busy_later", busy, 1'b0);

        // Write to the nibble being appended on the same tick
        cur_len = 5'd10;
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle();
        wait_en(10, c);
        for (int k = 0; k < TD - 1; k++) idle();
        step(1'b1, 4'd5, 4'hF, 1'b0, 1'b0);
        check_eq("hazard_old_d", d, 16'h2345);
        for (int k = 0; k < 10; k++) wait_en(10, c);
        check_eq("hazard_new_d", d, 16'h234F);

        // Asynchronous reset mid-scroll
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_d", d, 16'h0);
        check_eq("arst_en", en, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_wrap", wrap, 1'b0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        cur_len = 5'd16;
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle();
        check_eq("arst_buf_prime", d, 16'h0);
        for (int k = 0; k < 4; k++) begin
            wait_en(10, c);
            check_eq("arst_buf_d", d, 16'h0);
        end

        // Over-long length clamps to 16
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 4'($urandom), 1'b0, 1'b0);
        cur_len = 5'd20;
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle();
        first_wrap = 0;
        second_wrap = 0;
        for (int t = 1; t <= 30; t++) begin
            wait_en(10, c);
            if (wrap && first_wrap == 0) first_wrap = t;
            else if (wrap && second_wrap == 0) second_wrap = t;
        end
        check_eq("clamp_first_wrap", first_wrap, 12);
        check_eq("clamp_second_wrap", second_wrap, 28);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) cur_len = 5'($urandom);
            step(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
